// File: rtl/channel_burst_injector.sv
// Controlled-corruption channel between encoder and decoder: flips selected symbol bits using a
// periodic, LFSR-random or burst pattern and keeps symbol and flipped-bit counters per run.
module channel_burst_injector #(
  parameter int unsigned N    = 5,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  sym_i,
  input  logic        valid_i,
  input  logic        start_i,
  input  logic [1:0]  mode_i,
  input  logic [1:0]  mask_i,
  input  logic [3:0]  burst_len_i,
  input  logic [7:0]  rate_i,
  input  logic [15:0] window_i,
  output logic [1:0]  sym_o,
  output logic        valid_o,
  output logic        err_o,
  output logic [15:0] sym_ct_o,
  output logic [15:0] flip_ct_o,
  output logic        busy_o
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [1:0] ModePass     = 2'b00;
  localparam logic [1:0] ModePeriodic = 2'b01;
  localparam logic [1:0] ModeRandom   = 2'b10;
  localparam logic [1:0] ModeBurst    = 2'b11;

  // An all-zero seed would lock the LFSR.
  localparam logic [15:0] SeedEff = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [8:0]  Period  = 9'(2 ** N);

  logic [1:0]  state_q, state_d;
  logic [15:0] sym_ct_q, sym_ct_d;
  logic [15:0] flip_ct_q, flip_ct_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [1:0]  sym_q, sym_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;

  logic [8:0]  phase;
  logic [8:0]  burst_min;
  logic [8:0]  burst_thr;
  logic        hit;
  logic [1:0]  popcnt;
  logic [16:0] flip_sum;
  logic [15:0] flip_sat;
  logic [15:0] sym_ct_inc;
  logic [15:0] lfsr_step;

  always_comb begin
    phase     = 9'(sym_ct_q[N-1:0]);
    burst_min = ({5'd0, burst_len_i} > Period) ? Period : {5'd0, burst_len_i};
    burst_thr = Period - burst_min;
    unique case (mode_i)
      ModePeriodic: hit = (phase == Period - 9'd1);
      ModeRandom:   hit = (lfsr_q[7:0] < rate_i);
      ModeBurst:    hit = (phase >= burst_thr);
      ModePass:     hit = 1'b0;
      default:      hit = 1'b0;
    endcase
  end

  assign popcnt     = {1'b0, mask_i[0]} + {1'b0, mask_i[1]};
  assign flip_sum   = {1'b0, flip_ct_q} + {15'd0, popcnt};
  assign flip_sat   = flip_sum[16] ? 16'hFFFF : flip_sum[15:0];
  assign sym_ct_inc = sym_ct_q + 16'd1;

  // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
  assign lfsr_step = {lfsr_q[0], lfsr_q[15], lfsr_q[14] ^ lfsr_q[0], lfsr_q[13] ^ lfsr_q[0],
                      lfsr_q[12], lfsr_q[11] ^ lfsr_q[0], lfsr_q[10:1]};

  always_comb begin
    state_d   = state_q;
    sym_ct_d  = sym_ct_q;
    flip_ct_d = flip_ct_q;
    lfsr_d    = lfsr_q;
    valid_d   = valid_i;
    sym_d     = valid_i ? sym_i : 2'b00;
    err_d     = 1'b0;

    if (start_i) begin
      // The start symbol passes clean and is not counted.
      state_d   = StRun;
      sym_ct_d  = 16'd0;
      flip_ct_d = 16'd0;
    end else if (state_q == StRun && valid_i) begin
      sym_ct_d = sym_ct_inc;
      lfsr_d   = lfsr_step;
      if (hit) begin
        sym_d     = sym_i ^ mask_i;
        err_d     = 1'b1;
        flip_ct_d = flip_sat;
      end
      if (window_i != 16'd0 && sym_ct_inc == window_i) begin
        state_d = StDone;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      sym_ct_q  <= 16'd0;
      flip_ct_q <= 16'd0;
      lfsr_q    <= SeedEff;
      sym_q     <= 2'b00;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sym_ct_q  <= sym_ct_d;
      flip_ct_q <= flip_ct_d;
      lfsr_q    <= lfsr_d;
      sym_q     <= sym_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign sym_o     = sym_q;
  assign valid_o   = valid_q;
  assign err_o     = err_q;
  assign sym_ct_o  = sym_ct_q;
  assign flip_ct_o = flip_ct_q;
  assign busy_o    = (state_q == StRun);

endmodule
